// File: rtl/csa_sbox_pkg.sv
// Shared definitions for the CSA stream-cipher S-box engine: default tables,
// FSM state codes and a golden lookup used by both the RTL and its bench.
package csa_sbox_pkg;

    localparam int NUM_TABLES = 7;
    localparam int TABLE_DEPTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Packed so one register bank can be indexed as tbl[sbox][addr].
    typedef logic [NUM_TABLES-1:0][TABLE_DEPTH-1:0][1:0] table_t;

    localparam int SBOX_ROM [NUM_TABLES][TABLE_DEPTH] = '{
        '{2, 0, 1, 1, 2, 3, 3, 0, 3, 2, 2, 0, 1, 1, 0, 3,
          0, 3, 3, 0, 2, 2, 1, 1, 2, 2, 0, 3, 1, 1, 3, 0},
        '{3, 1, 0, 2, 2, 3, 3, 0, 1, 3, 2, 1, 0, 0, 1, 2,
          3, 1, 0, 3, 3, 2, 0, 2, 0, 0, 1, 2, 2, 1, 3, 1},
        '{2, 0, 1, 2, 2, 3, 3, 1, 1, 1, 0, 3, 3, 0, 2, 0,
          1, 3, 0, 1, 3, 0, 2, 2, 2, 0, 1, 2, 0, 3, 3, 1},
        '{3, 1, 2, 3, 0, 2, 1, 2, 1, 2, 0, 1, 3, 0, 0, 3,
          1, 0, 3, 1, 2, 3, 0, 3, 0, 3, 2, 0, 1, 2, 2, 1},
        '{2, 0, 0, 1, 3, 2, 3, 2, 0, 1, 3, 3, 1, 0, 2, 1,
          2, 3, 2, 0, 0, 3, 1, 1, 1, 0, 3, 2, 3, 1, 0, 2},
        '{0, 1, 2, 3, 1, 2, 2, 0, 0, 1, 3, 0, 2, 3, 1, 3,
          2, 3, 0, 2, 3, 0, 1, 1, 2, 1, 1, 2, 0, 3, 3, 0},
        '{0, 3, 2, 2, 3, 0, 0, 1, 3, 0, 1, 3, 1, 2, 2, 1,
          1, 0, 3, 3, 0, 1, 1, 2, 2, 3, 1, 0, 2, 3, 0, 2}
    };

    // sel 0..6 selects S-box 1..7; sel 7 has no table and reads as zero.
    function automatic logic [1:0] sbox_lookup(input logic [2:0] sel, input logic [4:0] addr);
        logic [1:0] r;
        r = 2'b00;
        if (int'(sel) < NUM_TABLES) r = 2'(SBOX_ROM[sel][addr]);
        return r;
    endfunction

    function automatic table_t default_tables();
        table_t t;
        for (int s = 0; s < NUM_TABLES; s++)
            for (int a = 0; a < TABLE_DEPTH; a++)
                t[s][a] = 2'(SBOX_ROM[s][a]);
        return t;
    endfunction

endpackage

// File: rtl/csa_sbox_unit.sv
// One combinational S-box lookup unit: fixed ROM or the writable table bank.
module csa_sbox_unit
    import csa_sbox_pkg::*;
#(
    parameter int LOADABLE = 0
) (
    input  logic [2:0] sel,
    input  logic [4:0] addr,
    input  table_t     tbl,
    output logic [1:0] data
);

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        data = 2'b00;
        if (int'(sel) < NUM_TABLES)
            data = (LOADABLE != 0) ? tbl[sel][addr] : sbox_lookup(sel, addr);
    end

endmodule

// File: rtl/csa_sbox_engine.sv
// Sequential CSA S-box evaluator: one request of NUM_SBOX indices is resolved
// over ceil(NUM_SBOX/UNITS) cycles using UNITS shared lookup units.
module csa_sbox_engine
    import csa_sbox_pkg::*;
#(
    parameter int NUM_SBOX = 7,
    parameter int UNITS    = 1,
    parameter int LOADABLE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5*NUM_SBOX-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUM_SBOX-1:0] out_data,
    output logic                  busy,
    input  logic                  tbl_we,
    input  logic [2:0]            tbl_sel,
    input  logic [4:0]            tbl_addr,
    input  logic [1:0]            tbl_wdata
);

    localparam int STEPS  = (NUM_SBOX + UNITS - 1) / UNITS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [1:0]            state;
    logic [STEP_W-1:0]     step;
    logic [5*NUM_SBOX-1:0] req;
    table_t                tbl;

    int         lane_idx  [UNITS];
    logic [2:0] unit_sel  [UNITS];
    logic [4:0] unit_addr [UNITS];
    logic [1:0] unit_res  [UNITS];

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // Lane mux: unit u serves lane step*UNITS+u; lanes past NUM_SBOX park on the empty sel 7.
    always_comb begin
        for (int u = 0; u < UNITS; u++) begin
            lane_idx[u]  = int'(step) * UNITS + u;
            unit_sel[u]  = 3'd7;
            unit_addr[u] = 5'd0;
            if (lane_idx[u] < NUM_SBOX) begin
                unit_sel[u]  = 3'(lane_idx[u]);
                unit_addr[u] = req[5*lane_idx[u] +: 5];
            end
        end
    end

    for (genvar g = 0; g < UNITS; g++) begin : g_unit
        csa_sbox_unit #(.LOADABLE(LOADABLE)) u_unit (
            .sel  (unit_sel[g]),
            .addr (unit_addr[g]),
            .tbl  (tbl),
            .data (unit_res[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= '0;
            req      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        req   <= in_data;
                        step  <= '0;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    for (int u = 0; u < UNITS; u++)
                        if (lane_idx[u] < NUM_SBOX)
                            out_data[2*lane_idx[u] +: 2] <= unit_res[u];
                    if (step == STEP_W'(STEPS - 1)) state <= ST_DONE;
                    else                            step  <= step + 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the table bank is reset to the standard contents on every rst so a
    // test table never outlives a reset; it is only written while idle.
    always_ff @(posedge clk) begin
        if (rst)
            tbl <= default_tables();
        else if ((LOADABLE != 0) && tbl_we && (state == ST_IDLE) && (tbl_sel != 3'd7))
            tbl[tbl_sel][tbl_addr] <= tbl_wdata;
    end

endmodule

// File: tb/tb_csa_sbox_engine.sv
// Directed bench for csa_sbox_engine: three configurations (UNITS 7/2/1, loadable and fixed).
module tb_csa_sbox_engine;
    import csa_sbox_pkg::*;

    localparam int A = 0;  // UNITS=7, LOADABLE=1
    localparam int B = 1;  // UNITS=2, LOADABLE=0
    localparam int C = 2;  // UNITS=1, LOADABLE=1

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       in_valid, out_ready, tbl_we;
    logic [2:0]       in_ready, out_valid, busy;
    logic [2:0][34:0] in_data;
    logic [2:0][13:0] out_data;
    logic [2:0]       tbl_sel;
    logic [4:0]       tbl_addr;
    logic [1:0]       tbl_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    csa_sbox_engine #(.NUM_SBOX(7), .UNITS(7), .LOADABLE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[A]), .in_ready(in_ready[A]),
        .in_data(in_data[A]), .out_valid(out_valid[A]), .out_ready(out_ready[A]),
        .out_data(out_data[A]), .busy(busy[A]), .tbl_we(tbl_we[A]),
        .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
    );

    csa_sbox_engine #(.NUM_SBOX(7), .UNITS(2), .LOADABLE(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[B]), .in_ready(in_ready[B]),
        .in_data(in_data[B]), .out_valid(out_valid[B]), .out_ready(out_ready[B]),
        .out_data(out_data[B]), .busy(busy[B]), .tbl_we(tbl_we[B]),
        .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
    );

    csa_sbox_engine #(.NUM_SBOX(7), .UNITS(1), .LOADABLE(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[C]), .in_ready(in_ready[C]),
        .in_data(in_data[C]), .out_valid(out_valid[C]), .out_ready(out_ready[C]),
        .out_data(out_data[C]), .busy(busy[C]), .tbl_we(tbl_we[C]),
        .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
    );

    function automatic logic [13:0] model(input logic [34:0] d);
        logic [13:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r[2*k +: 2] = sbox_lookup(3'(k), d[5*k +: 5]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called from the first negedge after the accept edge; bounded wait for out_valid.
    task automatic wait_done(input int d, output int lat, output int viol);
        lat  = 1;
        viol = 0;
        while (!out_valid[d] && lat < 40) begin
            if (in_ready[d] || !busy[d]) viol++;
            @(negedge clk);
            lat++;
        end
        if (in_ready[d] || !busy[d]) viol++;
    endtask

    task automatic do_req(input int d, input logic [34:0] din, output logic [13:0] res,
                          output int lat, output int viol);
        in_data[d]  = din;
        in_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        wait_done(d, lat, viol);
        res = out_data[d];
    endtask

    task automatic release_out(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic tbl_write(input int d, input logic [2:0] s, input logic [4:0] a, input logic [1:0] v);
        tbl_sel      = s;
        tbl_addr     = a;
        tbl_wdata    = v;
        tbl_we[d]    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tbl_we[d] = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [34:0] din;
        logic [1:0]  lane1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [13:0] res, exp, kept;
        logic [34:0] din, din1;
        logic [1:0]  newv;
        int          lat, viol, unstable, seen;

        vecs[0] = '{name: "lane1_00", din: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, lane1: 2'h3};
        vecs[1] = '{name: "lane1_03", din: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h03, 5'h00}, lane1: 2'h2};
        vecs[2] = '{name: "lane1_1f", din: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00}, lane1: 2'h1};
        vecs[3] = '{name: "lane1_14", din: {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h14, 5'h00}, lane1: 2'h3};
        vecs[4] = '{name: "mix_a",    din: {5'h1F, 5'h0A, 5'h11, 5'h05, 5'h1C, 5'h14, 5'h07}, lane1: 2'h3};
        vecs[5] = '{name: "mix_b",    din: {5'h15, 5'h02, 5'h1E, 5'h09, 5'h13, 5'h1F, 5'h0C}, lane1: 2'h1};

        rst = 1'b1;
        in_valid = '0; out_ready = '0; tbl_we = '0; in_data = '0;
        tbl_sel = '0; tbl_addr = '0; tbl_wdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_out_valid_%0d", d), out_valid[d], 1'b0);
            check($sformatf("rst_busy_%0d", d), busy[d], 1'b0);
            check($sformatf("rst_in_ready_%0d", d), in_ready[d], 1'b0);
            check($sformatf("rst_out_data_%0d", d), out_data[d], 14'h0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 3'b111);
        @(negedge clk);

        // Full-width evaluation: hand values on lane 1, model on every lane.
        for (int i = 0; i < 6; i++) begin
            do_req(A, vecs[i].din, res, lat, viol);
            check({vecs[i].name, "_lat"}, lat, 2);
            check({vecs[i].name, "_lane1"}, res[3:2], vecs[i].lane1);
            check({vecs[i].name, "_all"}, res, model(vecs[i].din));
            release_out(A);
            check({vecs[i].name, "_drop"}, out_valid[A], 1'b0);
        end

        // Two units per cycle: latency, handshake flags, and tbl_* ignored without LOADABLE.
        tbl_write(B, 3'd0, 5'h00, ~sbox_lookup(3'd0, 5'h00));
        for (int i = 0; i < 3; i++) begin
            din = 35'({$urandom(), $urandom()});
            do_req(B, din, res, lat, viol);
            check($sformatf("u2_lat_%0d", i), lat, 5);
            check($sformatf("u2_flags_%0d", i), viol, 0);
            check($sformatf("u2_data_%0d", i), res, model(din));
            release_out(B);
        end
        do_req(B, 35'h0, res, lat, viol);
        check("rom_ignores_write", res, model(35'h0));
        release_out(B);

        // Backpressure with a pending request that must wait for the handshake.
        din = 35'h5_1234_5678;
        do_req(B, din, res, lat, viol);
        kept = res;
        unstable = 0;
        din1 = '0;
        for (int i = 0; i < 10; i++) begin
            din1        = 35'({$urandom(), $urandom()});
            in_data[B]  = din1;
            in_valid[B] = 1'b1;
            @(negedge clk);
            if (!out_valid[B] || out_data[B] !== kept || in_ready[B] || !busy[B]) unstable++;
        end
        check("bp_stable", unstable, 0);
        out_ready[B] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[B] = 1'b0;
        check("bp_ready_after_hs", in_ready[B], 1'b1);
        check("bp_no_accept_at_hs", busy[B], 1'b0);
        check("bp_valid_dropped", out_valid[B], 1'b0);
        check("bp_data_kept", out_data[B], kept);
        @(posedge clk);
        @(negedge clk);
        in_valid[B] = 1'b0;
        check("bp_late_accept", busy[B], 1'b1);
        wait_done(B, lat, viol);
        check("bp_late_lat", lat, 5);
        check("bp_late_data", out_data[B], model(din1));
        release_out(B);

        // Loadable tables: idle write, writes in EVAL/DONE ignored, sel 7 ignored, rst restores.
        exp = model(35'h0);
        exp[3:2] = 2'h0;
        tbl_write(A, 3'd1, 5'h00, 2'h0);
        do_req(A, 35'h0, res, lat, viol);
        check("ld_write_lane1", res[3:2], 2'h0);
        check("ld_write_all", res, exp);
        release_out(A);

        din = {25'h0, 5'h03, 5'h00};
        in_data[A]  = din;
        in_valid[A] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[A] = 1'b0;
        tbl_sel = 3'd1; tbl_addr = 5'h03; tbl_wdata = 2'h0; tbl_we[A] = 1'b1;
        repeat (3) @(negedge clk);
        tbl_we[A] = 1'b0;
        check("ld_busy_write_cur", out_data[A][3:2], 2'h2);
        release_out(A);
        do_req(A, din, res, lat, viol);
        check("ld_busy_write_ignored", res[3:2], 2'h2);
        release_out(A);

        tbl_write(A, 3'd7, 5'h00, 2'h1);
        do_req(A, 35'h0, res, lat, viol);
        check("ld_sel7_ignored", res, exp);
        release_out(A);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(A, 35'h0, res, lat, viol);
        check("ld_rst_restores", res[3:2], 2'h3);
        release_out(A);

        // Index sweep on every lane at both ends of the UNITS range.
        for (int u = 0; u < 2; u++) begin
            int d;
            d = (u == 0) ? C : A;
            for (int idx = 0; idx < 32; idx++) begin
                din = {7{5'(idx)}};
                do_req(d, din, res, lat, viol);
                check($sformatf("sweep_d%0d_i%0d", d, idx), res, model(din));
                if (idx == 0) check($sformatf("sweep_lat_d%0d", d), lat, (d == C) ? 8 : 2);
                release_out(d);
            end
        end

        // Same-cycle write and accept: the request sees the new entry.
        newv = sbox_lookup(3'd4, 5'h05) ^ 2'b11;
        din  = {10'h0, 5'h05, 20'h0};
        exp  = model(din);
        exp[9:8] = newv;
        tbl_sel = 3'd4; tbl_addr = 5'h05; tbl_wdata = newv; tbl_we[C] = 1'b1;
        do_req(C, din, res, lat, viol);
        tbl_we[C] = 1'b0;
        check("same_cycle_write", res, exp);
        release_out(C);

        // Abort in the second EVAL cycle of a 7-step request.
        in_data[C]  = 35'h7_0F0F_0F0F;
        in_valid[C] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[C] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid[C], 1'b0);
        check("abort_out_data", out_data[C], 14'h0);
        check("abort_busy", busy[C], 1'b0);
        check("abort_in_ready_in_rst", in_ready[C], 1'b0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready[C], 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid[C] || busy[C]) seen++;
        end
        check("abort_no_output", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csa_sbox_engine.md
Name: csa_sbox_engine

Overview:
- Sequential evaluator for the seven 5-in/2-out CSA stream-cipher S-boxes.
- Accepts one request of NUM_SBOX 5-bit indices and resolves it over ceil(NUM_SBOX/UNITS) cycles, using UNITS shared lookup units.
- Returns the packed 2-bit results through a valid/ready handshake.
- Optional LOADABLE mode replaces the fixed ROMs with run-time writable tables, so alternate or test tables need no resynthesis.
- Sits between the stream-cipher state registers and the output combiner.

Parameters:
- NUM_SBOX, 7, number of lanes (1..7). Lane k uses S-box k+1.
- UNITS, 1, lookup units evaluated per cycle (1..NUM_SBOX). STEPS = ceil(NUM_SBOX/UNITS).
- LOADABLE, 0, 1 = register-based writable tables; 0 = fixed ROM.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  engine can accept a request
- in_data  in  5*NUM_SBOX  lane k index in bits [5k+4:5k]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  2*NUM_SBOX  lane k result in bits [2k+1:2k]
- busy  out  1  high in EVAL or DONE
- tbl_we  in  1  table write strobe (LOADABLE=1 only)
- tbl_sel  in  3  0..6 selects S-box 1..7; 7 is ignored
- tbl_addr  in  5  table entry
- tbl_wdata  in  2  entry value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, step counter=0. in_ready=0 while rst=1.
- LOADABLE=1 tables reset to the standard CSA contents, on every rst including mid-operation.
- States: IDLE, EVAL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data, clear step, go to EVAL.
- EVAL:
  - Each cycle computes lanes step*UNITS .. step*UNITS+UNITS-1.
  - Lanes >= NUM_SBOX are ignored.
  - Results are written into the out_data register at the clock edge; step increments.
  - After step==STEPS-1, go to DONE.
- DONE:
  - out_valid=1. out_data must stay stable until out_ready.
  - On out_ready, go to IDLE, drop out_valid, keep out_data as is.
- Latency: out_valid rises exactly STEPS+1 cycles after the accepting cycle.
- in_ready=0 throughout EVAL and DONE. Back-to-back overlap is not supported.
- out_data lanes not yet computed in EVAL hold old values. Consumers must sample only when out_valid=1.
- Table writes (LOADABLE=1):
  - Accepted only in IDLE; ignored in EVAL or DONE.
  - tbl_sel=7 is ignored.
  - A write in the same cycle as a request accept is visible to that request.
- LOADABLE=0: tbl_* inputs have no effect.
- in_valid held high without ready, or in_data changing while not ready, must not affect the engine.
- rst asserted during EVAL or DONE aborts the request and yields no output.

Decomposition:
- csa_sbox_pkg holds:
  - the seven default 32x2 tables as constants
  - the state enum
  - a golden lookup function (sbox index, addr) -> 2 bits, shared with the bench
- Sub-module csa_sbox_unit: combinational lookup (sel, addr) -> 2 bits.
  - Reads the pkg ROM, or the table registers when LOADABLE=1.
  - Instantiated UNITS times.
- Lane mux, FSM, step counter and table registers live in csa_sbox_engine.

Test Plan:
1. NUM_SBOX=7, UNITS=7, lane1 index 0x00, other lanes 0 -> lane1 result 2'h3 after 2 cycles; all lanes match the pkg model. Repeat lane1=0x03 -> 2'h2, 0x1F -> 2'h1, 0x14 -> 2'h3.
2. UNITS=2, random in_data -> out_valid exactly 5 cycles after accept, out_data matches the model. in_ready=0 and busy=1 from accept until out_ready.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable. A new in_valid is not accepted until one cycle after the out_ready handshake.
4. LOADABLE=1: write sel=1, addr=0x00, data=2'h0 in IDLE, then request lane1=0x00 -> 2'h0. Write attempted during EVAL -> ignored. rst -> entry reverts to 2'h3.
5. Assert rst in the second EVAL cycle (UNITS=1) -> next cycle out_valid=0, out_data=0, busy=0. in_ready=1 once rst drops; the aborted request never produces output.
6. Sweep all 32 indices on all lanes, UNITS=1 and UNITS=7 -> 224/224 entries match the model. Same-cycle write plus accept uses the new value.
